// File: rtl/prog_sequencer.sv
// Run controller: launches one of NUM_PROGS resident programs via the PC start
// pulse, enables the datapath until halt or watchdog, then reports completion.
module prog_sequencer #(
  parameter int NUM_PROGS  = 4,
  parameter int PC_W       = 10,
  parameter int CNT_W      = 16,
  parameter int PROG0_ADDR = 0,
  parameter int PROG1_ADDR = 128,
  parameter int PROG2_ADDR = 256,
  parameter int PROG3_ADDR = 384,
  parameter int MAX_CYCLES = 65535
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             req,
  input  logic [1:0]       prog_sel,
  input  logic             halt,
  output logic             start,
  output logic [PC_W-1:0]  start_address,
  output logic             run_en,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic             err,
  output logic [CNT_W-1:0] cycle_count,
  output logic [1:0]       last_prog
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] WD_LIM  = CNT_W'(MAX_CYCLES);

  state_e            state_q, state_d;
  logic [PC_W-1:0]   addr_q, addr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        prog_q, prog_d;
  logic              tmo_q, tmo_d;
  logic              err_q, err_d;
  logic              sel_ok;
  logic [PC_W-1:0]   sel_addr;

  assign sel_ok = 32'(prog_sel) < NUM_PROGS;

  always_comb begin
    sel_addr = PC_W'(PROG0_ADDR);
    case (prog_sel)
      2'd1:    sel_addr = PC_W'(PROG1_ADDR);
      2'd2:    sel_addr = PC_W'(PROG2_ADDR);
      2'd3:    sel_addr = PC_W'(PROG3_ADDR);
      default: sel_addr = PC_W'(PROG0_ADDR);
    endcase
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    prog_d  = prog_q;
    tmo_d   = tmo_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          if (sel_ok) begin
            prog_d  = prog_sel;
            addr_d  = sel_addr;
            tmo_d   = 1'b0;
            state_d = LOAD;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      LOAD: begin
        cnt_d   = '0;
        state_d = RUN;
      end
      RUN: begin
        cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        // Halt takes priority over a watchdog expiry in the same cycle.
        if (halt) begin
          tmo_d   = 1'b0;
          state_d = DONE;
        end else if (cnt_d >= WD_LIM) begin
          tmo_d   = 1'b1;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= PC_W'(PROG0_ADDR);
      cnt_q   <= '0;
      prog_q  <= '0;
      tmo_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      prog_q  <= prog_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
    end
  end

  assign start         = (state_q == LOAD);
  assign run_en        = (state_q == RUN);
  assign busy          = (state_q == LOAD) || (state_q == RUN);
  assign done          = (state_q == DONE);
  assign timeout       = tmo_q;
  assign err           = err_q;
  assign start_address = addr_q;
  assign cycle_count   = cnt_q;
  assign last_prog     = prog_q;

endmodule

// File: tb/tb_prog_sequencer.sv
// Directed bench for prog_sequencer with a short watchdog and three programs
// so both the watchdog and out-of-range selection are reachable quickly.
module tb_prog_sequencer;
  localparam int PC_W  = 10;
  localparam int CNT_W = 16;

  logic             CLK = 1'b0;
  logic             reset, req, halt;
  logic [1:0]       prog_sel;
  logic             start, run_en, busy, done, timeout, err;
  logic [PC_W-1:0]  start_address;
  logic [CNT_W-1:0] cycle_count;
  logic [1:0]       last_prog;

  int n_chk = 0;
  int n_err = 0;
  int start_seen;

  prog_sequencer #(.NUM_PROGS(3), .PC_W(PC_W), .CNT_W(CNT_W), .MAX_CYCLES(20)) dut (
    .CLK(CLK), .reset(reset), .req(req), .prog_sel(prog_sel), .halt(halt),
    .start(start), .start_address(start_address), .run_en(run_en), .busy(busy),
    .done(done), .timeout(timeout), .err(err), .cycle_count(cycle_count),
    .last_prog(last_prog)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got hang expected finish");
    $fatal(1);
  end

  initial begin
    reset = 1; req = 0; halt = 0; prog_sel = 0;
    step(); step();
    chk("rst_start", start, 0);
    chk("rst_run_en", run_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_err", err, 0);
    chk("rst_cnt", cycle_count, 0);
    chk("rst_last", last_prog, 0);
    chk("rst_addr", start_address, 0);

    // halt in IDLE must not do anything
    reset = 0; halt = 1;
    step(); step();
    chk("idle_halt_busy", busy, 0);
    chk("idle_halt_done", done, 0);
    chk("idle_halt_start", start, 0);

    // program 2, halt on RUN cycle 5
    halt = 0; req = 1; prog_sel = 2;
    step();
    chk("p2_start", start, 1);
    chk("p2_addr", start_address, 256);
    chk("p2_busy", busy, 1);
    req = 0;
    step();
    chk("p2_run_en", run_en, 1);
    chk("p2_start_off", start, 0);
    chk("p2_cnt0", cycle_count, 0);
    step(); step(); step(); step();
    halt = 1;
    step();
    chk("p2_done", done, 1);
    chk("p2_cnt", cycle_count, 5);
    chk("p2_tmo", timeout, 0);
    chk("p2_last", last_prog, 2);
    chk("p2_done_busy", busy, 0);
    chk("p2_done_run_en", run_en, 0);
    halt = 0;
    step();
    chk("p2_done_pulse", done, 0);
    chk("p2_cnt_hold", cycle_count, 5);

    // program 1, watchdog, req toggled during RUN
    req = 1; prog_sel = 1;
    step();
    chk("wd_addr", start_address, 128);
    req = 0;
    step();
    start_seen = 0;
    for (int i = 0; i < 19; i++) begin
      req = i[0];
      step();
      if (start) start_seen++;
    end
    chk("wd_no_restart", start_seen, 0);
    chk("wd_run20", run_en, 1);
    chk("wd_cnt19", cycle_count, 19);
    req = 1;
    step();
    chk("wd_done", done, 1);
    chk("wd_tmo", timeout, 1);
    chk("wd_cnt", cycle_count, 20);
    step();
    chk("wd_idle_start", start, 0);
    chk("wd_idle_tmo_hold", timeout, 1);
    // req held high: relaunch right after the IDLE cycle
    step();
    chk("b2b_start", start, 1);
    chk("b2b_tmo_clr", timeout, 0);
    req = 0;
    step();
    chk("b2b_cnt0", cycle_count, 0);
    for (int i = 0; i < 19; i++) step();
    halt = 1;
    step();
    chk("hw_done", done, 1);
    chk("hw_tmo", timeout, 0);
    chk("hw_cnt", cycle_count, 20);
    halt = 0;
    step();

    // out-of-range program
    req = 1; prog_sel = 3;
    step();
    chk("oor_err", err, 1);
    chk("oor_busy", busy, 0);
    chk("oor_start", start, 0);
    chk("oor_last", last_prog, 1);
    req = 0;
    step();
    chk("oor_err_pulse", err, 0);
    chk("oor_start2", start, 0);

    // reset on RUN cycle 3
    req = 1; prog_sel = 0;
    step();
    chk("r3_addr", start_address, 0);
    req = 0;
    step(); step(); step();
    chk("r3_cnt2", cycle_count, 2);
    reset = 1;
    step();
    chk("r3_run_en", run_en, 0);
    chk("r3_cnt", cycle_count, 0);
    chk("r3_done", done, 0);
    chk("r3_busy", busy, 0);
    reset = 0;
    step();
    chk("r3_no_done", done, 0);
    req = 1; prog_sel = 2;
    step();
    chk("post_start", start, 1);
    chk("post_addr", start_address, 256);
    req = 0;
    step();
    halt = 1;
    step();
    chk("post_done", done, 1);
    chk("post_cnt", cycle_count, 1);
    chk("post_last", last_prog, 2);
    halt = 0;
    step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
